// File: rtl/imm_pkg.sv
// Shared definitions for the ARMv8 immediate generator: format codes and
// instruction field positions.
package imm_pkg;

  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_D  = 3'b001;
  localparam logic [2:0] FMT_B  = 3'b010;
  localparam logic [2:0] FMT_CB = 3'b011;
  localparam logic [2:0] FMT_IW = 3'b100;

  localparam int IMM12_LSB = 10;
  localparam int IMM9_LSB  = 12;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_LSB = 5;
  localparam int IMM16_LSB = 5;
  localparam int HW_LSB    = 21;
  localparam int SH_BIT    = 22;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  ctrl;
  } s1_t;

endpackage

// File: rtl/imm_extract_comb.sv
// Combinational immediate decode: extracts, extends and shifts the immediate
// for one instruction word according to the format select.
module imm_extract_comb
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit CHECK_HW = 1'b1
) (
  input  logic [31:0]       instr,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  logic [1:0] hw;
  logic       hw_oor;
  logic       unused;

  assign hw     = instr[HW_LSB +: 2];
  // A 32-bit datapath can only hold MOVZ halfwords 0 and 1.
  assign hw_oor = CHECK_HW && (DATA_W == 32) && hw[1];
  assign unused = ^instr[31:26];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (ctrl)
      FMT_I: begin
        if (instr[SH_BIT]) imm = DATA_W'({40'b0, instr[IMM12_LSB +: 12], 12'b0});
        else               imm = DATA_W'({52'b0, instr[IMM12_LSB +: 12]});
      end
      FMT_D:  imm = DATA_W'({{55{instr[IMM9_LSB + 8]}}, instr[IMM9_LSB +: 9]});
      FMT_B:  imm = DATA_W'({{36{instr[IMM26_LSB + 25]}}, instr[IMM26_LSB +: 26], 2'b00});
      FMT_CB: imm = DATA_W'({{43{instr[IMM19_LSB + 18]}}, instr[IMM19_LSB +: 19], 2'b00});
      FMT_IW: begin
        if (hw_oor) err = 1'b1;
        else        imm = DATA_W'({48'b0, instr[IMM16_LSB +: 16]} << {hw, 4'b0000});
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipelined immediate generator sitting between decode
// and register read; S1 holds the raw instruction, S2 the extended result.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit CHECK_HW = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr,
  input  logic [2:0]        Ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic              Err
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("imm_extend_pipe: DATA_W must be 32 or 64");
  end

  logic              s1_v;
  s1_t               s1;
  logic              s1_en;
  logic              s2_en;
  logic [DATA_W-1:0] s1_imm;
  logic              s1_err;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_v || s2_en;
  assign in_ready = s1_en;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) s1 <= '{instr: Instr, ctrl: Ctrl};
    end
  end

  imm_extract_comb #(
    .DATA_W  (DATA_W),
    .CHECK_HW(CHECK_HW)
  ) u_extract (
    .instr(s1.instr),
    .ctrl (s1.ctrl),
    .imm  (s1_imm),
    .err  (s1_err)
  );

  // NOTE: the S2 data registers are reset too, because BusImm and Err must
  // read zero while Reset is high, not just be qualified by out_valid.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      BusImm    <= '0;
      Err       <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_v;
      if (s1_v) begin
        BusImm <= s1_imm;
        Err    <= s1_err;
      end
    end
  end

endmodule
